// File: rtl/noc_pkg.sv
// Shared NoC router definitions: packet layout, output port indices,
// source-ID tokens and the XY route decision.
package noc_pkg;

    localparam int unsigned PKT_W   = 11;
    localparam int unsigned COORD_W = 2;
    localparam int unsigned DEST_HI = 10;
    localparam int unsigned DEST_LO = 7;
    localparam int unsigned DEST_W  = DEST_HI - DEST_LO + 1;
    localparam int unsigned N_PORTS = 5;
    localparam int unsigned SRC_W   = 3;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t P_EAST  = 3'd0;
    localparam port_idx_t P_WEST  = 3'd1;
    localparam port_idx_t P_NORTH = 3'd2;
    localparam port_idx_t P_SOUTH = 3'd3;
    localparam port_idx_t P_CORE  = 3'd4;

    localparam logic [SRC_W-1:0] SRC_IN1  = 3'b000;
    localparam logic [SRC_W-1:0] SRC_IN2  = 3'b001;
    localparam logic [SRC_W-1:0] SRC_IN3  = 3'b010;
    localparam logic [SRC_W-1:0] SRC_IN4  = 3'b011;
    localparam logic [SRC_W-1:0] SRC_CORE = 3'b100;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_RET  = 2'd2,
        TX_DONE = 2'd3
    } tx_state_e;

    // X is resolved before Y; a destination equal to this node goes to the core.
    function automatic port_idx_t xy_route(
        input logic [DEST_W-1:0]  dest,
        input logic [COORD_W-1:0] my_x,
        input logic [COORD_W-1:0] my_y
    );
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = dest[DEST_W-1:COORD_W];
        dy = dest[COORD_W-1:0];
        if (dx > my_x)      return P_EAST;
        else if (dx < my_x) return P_WEST;
        else if (dy > my_y) return P_NORTH;
        else if (dy < my_y) return P_SOUTH;
        else                return P_CORE;
    endfunction

endpackage

// File: rtl/hs4_tx.sv
// Single 4-phase sender: raises req on go, waits ack high then ack low,
// then parks in DONE until the owner clears it.
module hs4_tx
    import noc_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_go,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_req,
    output logic o_busy,
    output logic o_done
);

    tx_state_e r_state;
    tx_state_e w_state_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE: if (i_go)    w_state_nxt = TX_REQ;
            TX_REQ:  if (i_ack)   w_state_nxt = TX_RET;
            TX_RET:  if (!i_ack)  w_state_nxt = TX_DONE;
            TX_DONE: if (i_clear) w_state_nxt = TX_IDLE;
            default:              w_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        o_req  = (r_state == TX_REQ);
        o_busy = (r_state != TX_IDLE);
        o_done = (r_state == TX_DONE);
    end

endmodule

// File: rtl/router_split.sv
// Router input-side splitter: accepts one packet over a 4-phase link, XY-routes
// it and sends data plus a source-ID control token to the selected output.
module router_split
    import noc_pkg::*;
#(
    parameter int unsigned      MY_X = 2,
    parameter int unsigned      MY_Y = 2,
    parameter logic [SRC_W-1:0] ID   = SRC_IN1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_req,
    input  logic [PKT_W-1:0]   in_data,
    output logic               in_ack,
    output logic [N_PORTS-1:0] out_req,
    input  logic [N_PORTS-1:0] out_ack,
    output logic [PKT_W-1:0]   out_data,
    output logic [N_PORTS-1:0] ctl_req,
    input  logic [N_PORTS-1:0] ctl_ack,
    output logic [SRC_W-1:0]   ctl_data
);

    localparam logic [COORD_W-1:0] C_MY_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] C_MY_Y = COORD_W'(MY_Y);

    logic               r_in_ack;
    logic [N_PORTS-1:0] r_sel;
    logic [PKT_W-1:0]   r_data;

    logic               w_full;
    logic               w_load;
    logic               w_clear;
    port_idx_t          w_route;
    logic [N_PORTS-1:0] w_sel_nxt;
    logic               w_data_ack;
    logic               w_ctl_ack;
    logic               w_data_req;
    logic               w_ctl_req;
    logic               w_data_busy;
    logic               w_ctl_busy;
    logic               w_data_done;
    logic               w_ctl_done;

    // The buffer is full exactly while either sender is away from IDLE; both
    // return to IDLE together on the clearing edge.
    assign w_full    = w_data_busy | w_ctl_busy;
    assign w_load    = in_req & ~r_in_ack & ~w_full;
    assign w_clear   = w_data_done & w_ctl_done;
    assign w_route   = xy_route(in_data[DEST_HI:DEST_LO], C_MY_X, C_MY_Y);
    assign w_sel_nxt = N_PORTS'(1) << w_route;

    assign w_data_ack = |(out_ack & r_sel);
    assign w_ctl_ack  = |(ctl_ack & r_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ack <= 1'b0;
            r_sel    <= '0;
            r_data   <= '0;
        end else if (w_load) begin
            r_in_ack <= 1'b1;
            r_sel    <= w_sel_nxt;
            r_data   <= in_data;
        end else if (r_in_ack && !in_req) begin
            r_in_ack <= 1'b0;
        end
    end

    hs4_tx u_data_tx (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_go    (w_load),
        .i_ack   (w_data_ack),
        .i_clear (w_clear),
        .o_req   (w_data_req),
        .o_busy  (w_data_busy),
        .o_done  (w_data_done)
    );

    hs4_tx u_ctl_tx (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_go    (w_load),
        .i_ack   (w_ctl_ack),
        .i_clear (w_clear),
        .o_req   (w_ctl_req),
        .o_busy  (w_ctl_busy),
        .o_done  (w_ctl_done)
    );

    assign in_ack   = r_in_ack;
    assign out_req  = w_data_req ? r_sel : '0;
    assign ctl_req  = w_ctl_req  ? r_sel : '0;
    assign out_data = r_data;
    assign ctl_data = ID;

endmodule

// File: tb/tb_router_split.sv
// Bench for router_split: directed scenarios plus random 4-phase traffic,
// checked every cycle against a packet-level reference model.
module tb_router_split;

    localparam int MY_X = 1;
    localparam int MY_Y = 2;
    localparam logic [2:0] TB_ID = 3'b011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_req = 1'b0;
    logic [10:0] in_data = '0;
    logic        in_ack;
    logic [4:0]  out_req;
    logic [4:0]  out_ack = '0;
    logic [10:0] out_data;
    logic [4:0]  ctl_req;
    logic [4:0]  ctl_ack = '0;
    logic [2:0]  ctl_data;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    router_split #(.MY_X(MY_X), .MY_Y(MY_Y), .ID(TB_ID)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data),
        .in_ack(in_ack), .out_req(out_req), .out_ack(out_ack),
        .out_data(out_data), .ctl_req(ctl_req), .ctl_ack(ctl_ack),
        .ctl_data(ctl_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_port(input logic [10:0] d);
        int dx;
        int dy;
        dx = int'(d[10:9]);
        dy = int'(d[8:7]);
        if (dx > MY_X) return 0;
        if (dx < MY_X) return 1;
        if (dy > MY_Y) return 2;
        if (dy < MY_Y) return 3;
        return 4;
    endfunction

    // Reference model: a packet is either absent or in flight to one port;
    // each channel progresses 0 = waiting for ack, 1 = waiting for ack release, 2 = finished.
    logic        m_in_ack = 1'b0;
    logic        m_busy = 1'b0;
    int          m_port = 0;
    logic [10:0] m_data = '0;
    int          m_ds = 0;
    int          m_cs = 0;
    logic        m_load;
    logic        m_a;
    logic        m_c;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in_ack = 1'b0;
            m_busy = 1'b0;
            m_port = 0;
            m_data = '0;
            m_ds = 0;
            m_cs = 0;
        end else begin
            m_load = !m_busy && !m_in_ack && in_req;
            if (m_in_ack && !in_req) m_in_ack = 1'b0;
            if (m_busy) begin
                if (m_ds == 2 && m_cs == 2) begin
                    m_busy = 1'b0;
                end else begin
                    m_a = out_ack[m_port];
                    m_c = ctl_ack[m_port];
                    if (m_ds == 0 && m_a) m_ds = 1;
                    else if (m_ds == 1 && !m_a) m_ds = 2;
                    if (m_cs == 0 && m_c) m_cs = 1;
                    else if (m_cs == 1 && !m_c) m_cs = 2;
                end
            end else if (m_load) begin
                m_busy = 1'b1;
                m_in_ack = 1'b1;
                m_port = ref_port(in_data);
                m_data = in_data;
                m_ds = 0;
                m_cs = 0;
            end
        end
    end

    logic [4:0] e_out_req;
    logic [4:0] e_ctl_req;

    always @(negedge clk) begin
        e_out_req = (m_busy && m_ds == 0) ? (5'd1 << m_port) : 5'd0;
        e_ctl_req = (m_busy && m_cs == 0) ? (5'd1 << m_port) : 5'd0;
        chk("cyc in_ack", 32'(in_ack), 32'(m_in_ack));
        chk("cyc out_req", 32'(out_req), 32'(e_out_req));
        chk("cyc ctl_req", 32'(ctl_req), 32'(e_ctl_req));
        chk("cyc out_data", 32'(out_data), 32'(m_data));
        chk("cyc ctl_data", 32'(ctl_data), 32'(TB_ID));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [10:0] d);
        chk("pre-load in_ack", 32'(in_ack), 32'd0);
        in_req = 1'b1;
        in_data = d;
        tick();
    endtask

    task automatic finish_port(input int p);
        out_ack[p] = 1'b1;
        ctl_ack[p] = 1'b1;
        tick();
        chk("fin out_req low", 32'(out_req), 32'd0);
        chk("fin ctl_req low", 32'(ctl_req), 32'd0);
        out_ack[p] = 1'b0;
        ctl_ack[p] = 1'b0;
        tick();
        tick();
    endtask

    task automatic skew(input logic ctl_first, input logic [10:0] nxt, input logic [4:0] nxt_oh);
        send(11'h7A5);
        in_req = 1'b0;
        tick();
        chk("skew in_ack released", 32'(in_ack), 32'd0);
        in_req = 1'b1;
        in_data = nxt;
        if (ctl_first) ctl_ack[0] = 1'b1; else out_ack[0] = 1'b1;
        tick();
        chk("skew hold1", 32'(in_ack), 32'd0);
        if (ctl_first) ctl_ack[0] = 1'b0; else out_ack[0] = 1'b0;
        tick();
        chk("skew hold2", 32'(in_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skew wait in_ack", 32'(in_ack), 32'd0);
            chk("skew first chan low", 32'(ctl_first ? ctl_req : out_req), 32'd0);
            chk("skew second chan up", 32'(ctl_first ? out_req : ctl_req), 32'd1);
        end
        if (ctl_first) out_ack[0] = 1'b1; else ctl_ack[0] = 1'b1;
        tick();
        chk("skew hold3", 32'(in_ack), 32'd0);
        if (ctl_first) out_ack[0] = 1'b0; else ctl_ack[0] = 1'b0;
        tick();
        chk("skew both done no load", 32'(in_ack), 32'd0);
        tick();
        chk("skew empty edge no load", 32'(in_ack), 32'd0);
        tick();
        chk("skew reload in_ack", 32'(in_ack), 32'd1);
        chk("skew reload out_req", 32'(out_req), 32'(nxt_oh));
        chk("skew reload ctl_req", 32'(ctl_req), 32'(nxt_oh));
        in_req = 1'b0;
        tick();
        finish_port(ref_port(nxt));
    endtask

    logic [10:0] rt_data [4] = '{11'h1AB, 11'h3FF, 11'h2C0, 11'h305};
    logic [4:0]  rt_oh   [4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("reset in_ack", 32'(in_ack), 32'd0);
        chk("reset out_req", 32'(out_req), 32'd0);
        chk("reset ctl_req", 32'(ctl_req), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        tick();

        // First packet: east, one-edge latency.
        send(11'h7A5);
        chk("t1 in_ack", 32'(in_ack), 32'd1);
        chk("t1 out_req", 32'(out_req), 32'h01);
        chk("t1 ctl_req", 32'(ctl_req), 32'h01);
        chk("t1 out_data", 32'(out_data), 32'h7A5);
        chk("t1 ctl_data", 32'(ctl_data), 32'(TB_ID));
        chk("t1 model port", 32'(m_port), 32'd0);
        in_req = 1'b0;
        tick();
        chk("t1 in_ack drop", 32'(in_ack), 32'd0);
        finish_port(0);

        for (int i = 0; i < 4; i++) begin
            send(rt_data[i]);
            chk("route out_req", 32'(out_req), 32'(rt_oh[i]));
            chk("route ctl_req", 32'(ctl_req), 32'(rt_oh[i]));
            chk("route model req", 32'(5'd1 << m_port), 32'(rt_oh[i]));
            chk("route out_data", 32'(out_data), 32'(rt_data[i]));
            in_req = 1'b0;
            tick();
            finish_port(i + 1);
        end

        skew(1'b0, 11'h1AB, 5'b00010);
        skew(1'b1, 11'h3FF, 5'b00100);

        // in_req held long after acceptance.
        send(11'h7A5);
        finish_port(0);
        for (int i = 0; i < 7; i++) begin
            chk("hold in_ack", 32'(in_ack), 32'd1);
            chk("hold no reload", 32'(out_req), 32'd0);
            tick();
        end
        in_req = 1'b0;
        tick();
        chk("hold release", 32'(in_ack), 32'd0);

        // Spurious ack on an unselected port.
        send(11'h7A5);
        in_req = 1'b0;
        out_ack[2] = 1'b1;
        tick();
        out_ack[2] = 1'b0;
        tick();
        chk("spur out_req", 32'(out_req), 32'h01);
        chk("spur ctl_req", 32'(ctl_req), 32'h01);
        finish_port(0);

        // Reset mid-transfer, request still pending afterwards.
        send(11'h2C0);
        chk("rst pre out_req", 32'(out_req), 32'h08);
        in_data = 11'h305;
        reset = 1'b1;
        #1;
        chk("rst imm in_ack", 32'(in_ack), 32'd0);
        chk("rst imm out_req", 32'(out_req), 32'd0);
        chk("rst imm ctl_req", 32'(ctl_req), 32'd0);
        chk("rst imm out_data", 32'(out_data), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst reload in_ack", 32'(in_ack), 32'd1);
        chk("rst reload out_req", 32'(out_req), 32'h10);
        chk("rst reload out_data", 32'(out_data), 32'h305);
        in_req = 1'b0;
        tick();
        finish_port(4);

        // Random traffic with a rule-following responder and stray acks.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                out_ack = '0;
                ctl_ack = '0;
                #2;
                reset = 1'b0;
            end else begin
                if (!in_req && !in_ack && $urandom_range(0, 3) == 0) begin
                    in_req = 1'b1;
                    in_data = 11'($urandom);
                end else if (in_req && in_ack && $urandom_range(0, 3) == 0) begin
                    in_req = 1'b0;
                end
                for (int p = 0; p < 5; p++) begin
                    if (out_req[p] && !out_ack[p]) begin
                        if ($urandom_range(0, 2) == 0) out_ack[p] = 1'b1;
                    end else if (out_ack[p]) begin
                        if ($urandom_range(0, 2) == 0) out_ack[p] = 1'b0;
                    end else if ($urandom_range(0, 49) == 0) begin
                        out_ack[p] = 1'b1;
                    end
                    if (ctl_req[p] && !ctl_ack[p]) begin
                        if ($urandom_range(0, 4) == 0) ctl_ack[p] = 1'b1;
                    end else if (ctl_ack[p]) begin
                        if ($urandom_range(0, 2) == 0) ctl_ack[p] = 1'b0;
                    end else if ($urandom_range(0, 49) == 0) begin
                        ctl_ack[p] = 1'b1;
                    end
                end
            end
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
